// File: rtl/demux_buffered_pkg.sv
// Shared constants for the buffered 1-to-2 demultiplexer.
//   WIDTH_DEF : default data width
//   DEPTH_DEF : default entries per output FIFO (power of two, >= 2)
//   CNT_W     : width of the per-output delivery counters
package demux_buffered_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 2;
  localparam int CNT_W     = 8;
endpackage

// File: rtl/demux_fifo.sv
// Single-clock FIFO used on each output path of demux_buffered.
// Ports:
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   i_push    : write i_data this edge (ignored when full)
//   i_data    : word to write
//   i_pop     : advance the read pointer this edge (ignored when empty)
//   o_full    : occupancy == DEPTH
//   o_empty   : occupancy == 0
//   o_head    : oldest stored word (0 after reset)
import demux_buffered_pkg::*;

module demux_fifo #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_occ;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_occ == (AW+1)'(DEPTH));
  assign o_empty = (r_occ == '0);
  assign o_head  = r_mem[r_rd_ptr];

  // Guard here as well so the FIFO is safe on its own.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Storage is cleared on reset so the head reads as zero afterwards.
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end
endmodule

// File: rtl/demux_buffered.sv
// Registered 1-to-2 demultiplexer with a small FIFO per output, so a
// stalled consumer blocks only its own path.
// Handshake: a transfer happens on an edge where valid & ready are both 1;
// ready never depends on the partner's valid, and data/valid are held by
// the producer until the transfer occurs.
// Ports:
//   clk, rst              : rising-edge clock, asynchronous active-high reset
//   in, in_valid, s       : input word, qualifier, select (0 -> out1, 1 -> out2)
//   in_ready              : selected FIFO not full and not in reset
//   out1/out1_valid/ready : head of FIFO 1 with handshake
//   out2/out2_valid/ready : head of FIFO 2 with handshake
//   cnt1, cnt2            : words delivered per output, modulo 256
import demux_buffered_pkg::*;

module demux_buffered #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  input  logic             s,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out2,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
);
  logic             w_full1, w_full2;
  logic             w_empty1, w_empty2;
  logic             w_push1, w_push2;
  logic             w_pop1, w_pop2;
  logic [CNT_W-1:0] r_cnt1, r_cnt2;

  // Depends only on s and fullness: a full FIFO never passes a word
  // through in the same cycle as a pop.
  assign in_ready = ~(s ? w_full2 : w_full1) & ~rst;

  assign w_push1 = in_valid & in_ready & ~s;
  assign w_push2 = in_valid & in_ready &  s;

  assign out1_valid = ~w_empty1;
  assign out2_valid = ~w_empty2;
  assign w_pop1     = out1_valid & out1_ready;
  assign w_pop2     = out2_valid & out2_ready;

  assign cnt1 = r_cnt1;
  assign cnt2 = r_cnt2;

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push1),
    .i_data  (in),
    .i_pop   (w_pop1),
    .o_full  (w_full1),
    .o_empty (w_empty1),
    .o_head  (out1)
  );

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo2 (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push2),
    .i_data  (in),
    .i_pop   (w_pop2),
    .o_full  (w_full2),
    .o_empty (w_empty2),
    .o_head  (out2)
  );

  // Delivery counters wrap modulo 2**CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt1 <= '0;
      r_cnt2 <= '0;
    end else begin
      if (w_pop1) r_cnt1 <= r_cnt1 + 1'b1;
      if (w_pop2) r_cnt2 <= r_cnt2 + 1'b1;
    end
  end
endmodule

// File: tb/tb_demux_buffered.sv
module tb_demux_buffered;
  localparam int W     = 32;
  localparam int DEPTH = 2;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         in_valid = 1'b0;
  logic         s = 1'b0;
  logic         in_ready;
  logic [W-1:0] out1, out2;
  logic         out1_valid, out2_valid;
  logic         out1_ready = 1'b1;
  logic         out2_ready = 1'b1;
  logic [7:0]   cnt1, cnt2;

  always #5 clk = ~clk;

  demux_buffered dut (
    .clk        (clk),
    .rst        (rst),
    .in         (din),
    .in_valid   (in_valid),
    .s          (s),
    .in_ready   (in_ready),
    .out1       (out1),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out2       (out2),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready),
    .cnt1       (cnt1),
    .cnt2       (cnt2)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per output, popped by the consumer
  // handshake and pushed by accepted input words.
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q2[$];
  logic [7:0]   m_cnt1 = '0;
  logic [7:0]   m_cnt2 = '0;
  bit           m_acc, m_p1, m_p2;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q1.delete();
      exp_q2.delete();
      m_cnt1 = '0;
      m_cnt2 = '0;
    end else begin
      m_acc = in_valid && (s ? (exp_q2.size() < DEPTH) : (exp_q1.size() < DEPTH));
      m_p1  = out1_ready && (exp_q1.size() != 0);
      m_p2  = out2_ready && (exp_q2.size() != 0);
      if (m_p1) begin void'(exp_q1.pop_front()); m_cnt1 = m_cnt1 + 8'd1; end
      if (m_p2) begin void'(exp_q2.pop_front()); m_cnt2 = m_cnt2 + 8'd1; end
      if (m_acc) begin
        if (s) exp_q2.push_back(din);
        else   exp_q1.push_back(din);
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  bit exp_rdy;
  always @(negedge clk) begin
    exp_rdy = !rst && (s ? (exp_q2.size() < DEPTH) : (exp_q1.size() < DEPTH));
    chk("in_ready", W'(in_ready), W'(exp_rdy));
    chk("out1_valid", W'(out1_valid), W'(exp_q1.size() != 0));
    chk("out2_valid", W'(out2_valid), W'(exp_q2.size() != 0));
    if (exp_q1.size() != 0) chk("out1", out1, exp_q1[0]);
    else if (rst)           chk("out1_rst", out1, '0);
    if (exp_q2.size() != 0) chk("out2", out2, exp_q2[0]);
    else if (rst)           chk("out2_rst", out2, '0);
    chk("cnt1", W'(cnt1), W'(m_cnt1));
    chk("cnt2", W'(cnt2), W'(m_cnt2));
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream n words, holding each until accepted; bounded by a cycle budget.
  task automatic stream(input int n, input bit alternate, input logic [W-1:0] base);
    int  k;
    int  guard;
    bit  acc;
    k = 0;
    guard = 0;
    while (k < n && guard < 4 * n + 20) begin
      s        = alternate ? k[0] : 1'b0;
      din      = base + W'(k);
      in_valid = 1'b1;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) k++;
      guard++;
    end
    in_valid = 1'b0;
    chk("stream_accepted", W'(k), W'(n));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset held for 3 cycles with random inputs.
    repeat (3) begin
      din        = $urandom;
      s          = 1'($urandom_range(0, 1));
      in_valid   = 1'($urandom_range(0, 1));
      out1_ready = 1'($urandom_range(0, 1));
      out2_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("rst_out1_valid", W'(out1_valid), '0);
    chk("rst_out2_valid", W'(out2_valid), '0);
    chk("rst_out1", out1, '0);
    chk("rst_out2", out2, '0);
    chk("rst_cnt1", W'(cnt1), '0);
    chk("rst_in_ready", W'(in_ready), '0);
    step();
    rst        = 1'b0;
    in_valid   = 1'b0;
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    step();

    // Routing
    s = 1'b0; din = 32'hDEADBEEF; in_valid = 1'b1;
    step();
    s = 1'b1; din = 32'h12345678;
    @(negedge clk);
    chk("route_out1", out1, 32'hDEADBEEF);
    chk("route_out1_valid", W'(out1_valid), 1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("route_out2", out2, 32'h12345678);
    chk("route_cnt1", W'(cnt1), 1);
    step();
    @(negedge clk);
    chk("route_cnt2", W'(cnt2), 1);
    step();

    // Backpressure on FIFO 1
    out1_ready = 1'b0; s = 1'b0; din = 1; in_valid = 1'b1;
    step();
    din = 2;
    step();
    din = 3;
    @(negedge clk);
    chk("bp_in_ready_full", W'(in_ready), 0);
    chk("bp_out1_head", out1, 1);
    step();
    @(negedge clk);
    chk("bp_out1_hold", out1, 1);
    step();
    out1_ready = 1'b1;
    step();
    @(negedge clk);
    chk("bp_out1_second", out1, 2);
    chk("bp_in_ready_free", W'(in_ready), 1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_out1_third", out1, 3);
    step();
    @(negedge clk);
    chk("bp_cnt1", W'(cnt1), 4);
    step();

    // Isolation: FIFO 1 full and stalled, FIFO 2 still flows
    out1_ready = 1'b0; s = 1'b0; in_valid = 1'b1; din = 32'hA;
    step();
    din = 32'hB;
    step();
    s = 1'b1; din = 32'hC;
    @(negedge clk);
    chk("iso_in_ready", W'(in_ready), 1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("iso_out2", out2, 32'hC);
    chk("iso_out1", out1, 32'hA);
    step();
    @(negedge clk);
    chk("iso_cnt2", W'(cnt2), 2);
    step();
    out1_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("iso_cnt1", W'(cnt1), 6);
    step();

    // Long alternating stream, then a one-sided stream that wraps cnt1
    stream(300, 1'b1, 32'h1000);
    repeat (3) step();
    @(negedge clk);
    chk("stream_cnt1", W'(cnt1), 156);
    chk("stream_cnt2", W'(cnt2), 152);
    step();
    stream(200, 1'b0, 32'h8000);
    repeat (3) step();
    @(negedge clk);
    chk("wrap_cnt1", W'(cnt1), 100);
    step();

    // Mid-operation asynchronous reset with FIFO 2 holding two words
    out2_ready = 1'b0; s = 1'b1; in_valid = 1'b1; din = 32'h11;
    step();
    din = 32'h22;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_out2_pre", out2, 32'h11);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_out2_valid", W'(out2_valid), 0);
    chk("mid_cnt2", W'(cnt2), 0);
    chk("mid_out2_zero", out2, 0);
    @(posedge clk);
    #1;
    rst = 1'b0; s = 1'b1; din = 32'h55; in_valid = 1'b1; out2_ready = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_out2", out2, 32'h55);
    chk("post_rst_valid", W'(out2_valid), 1);
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
